poly_horner_pipe: RTL and testbench

// - Parametrised successor to the fixed quadratic evaluator in basic_logic.
// - Evaluates y = C[D]*x^D + ... + C[1]*x + C[0] for any degree D with Horner's rule.
// - Uses a fully pipelined, valid/ready-streamed datapath with run-time loadable coefficients.
// - Sits between streaming sample sources and sinks; one sample/cycle when unstalled.

---
 rtl/poly_horner_pipe.sv | 158 +++++++++++++++
 tb/tb_poly_horner_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_horner_pipe.sv
`default_nettype none
// ============================================================================
// Module   : poly_horner_pipe
// Purpose  : Streaming polynomial evaluator,
//            y = C[D]*x^D + ... + C[1]*x + C[0].
//            It uses Horner's rule across DEGREE+1 registered stages and
//            accepts one sample per cycle when the output is not stalled.
//            The coefficients are loaded at run time and can only be
//            written while the pipeline is empty.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            coef_we/addr/wdata - coefficient write port (C[addr] <= wdata)
//            busy             - some stage holds a valid sample
//            in_valid/in_ready/x   - input sample stream
//            out_valid/out_ready/y - result stream
// Config   : POLY_HORNER_SAT_EN - when defined, every product and every sum
//            saturates to the signed WIDTH range. Otherwise they wrap
//            modulo 2^WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module poly_horner_pipe #(
  parameter int WIDTH  = 16,
  parameter int DEGREE = 3,
  parameter int ADDR_W = $clog2(DEGREE + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_we,
  input  logic [ADDR_W-1:0]       coef_addr,
  input  logic signed [WIDTH-1:0] coef_wdata,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y
);

`ifdef POLY_HORNER_SAT_EN
  localparam logic signed [2*WIDTH-1:0] c_pmax = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] c_pmin = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0]   c_max  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0]   c_min  = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // One Horner step: a*b + c, reduced to WIDTH bits.
  function automatic logic signed [WIDTH-1:0] horner_step(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] c
  );
`ifdef POLY_HORNER_SAT_EN
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   prod_sat;
    logic signed [WIDTH:0]     sum;
    logic signed [WIDTH-1:0]   res;
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    prod  = a_ext * b_ext;
    if (prod > c_pmax) begin
      prod_sat = c_max;
    end else if (prod < c_pmin) begin
      prod_sat = c_min;
    end else begin
      prod_sat = prod[WIDTH-1:0];
    end
    sum = {prod_sat[WIDTH-1], prod_sat} + {c[WIDTH-1], c};
    // The top two bits differ only when the WIDTH+1 sum has left the WIDTH range.
    if (sum[WIDTH] != sum[WIDTH-1]) begin
      res = sum[WIDTH] ? c_min : c_max;
    end else begin
      res = sum[WIDTH-1:0];
    end
    return res;
`else
    logic signed [WIDTH-1:0] prod_lo;
    // The low WIDTH bits of a product or a sum do not depend on the upper bits
    // that are discarded. So computing directly in WIDTH bits gives the
    // same result as wrapping the full-width values modulo 2^WIDTH.
    prod_lo = a * b;
    return prod_lo + c;
`endif
  endfunction

  logic                    rdy_en_q, rdy_en_d;
  logic [DEGREE:0]         valid_q, valid_d;
  logic signed [WIDTH-1:0] x_q    [0:DEGREE];
  logic signed [WIDTH-1:0] x_d    [0:DEGREE];
  logic signed [WIDTH-1:0] acc_q  [0:DEGREE];
  logic signed [WIDTH-1:0] acc_d  [0:DEGREE];
  logic signed [WIDTH-1:0] coef_q [0:DEGREE];
  logic signed [WIDTH-1:0] coef_d [0:DEGREE];

  logic advance;
  logic accept;
  logic coef_ok;

  // rdy_en_q holds in_ready low until the first clock edge after reset is released.
  assign out_valid = valid_q[DEGREE];
  assign y         = acc_q[DEGREE];
  assign busy      = |valid_q;
  assign advance   = !valid_q[DEGREE] || out_ready;
  assign in_ready  = rdy_en_q && advance;
  assign accept    = in_valid && in_ready;
  // Writes are only taken while the pipeline is empty. This guarantees that
  // every sample in flight sees a single coefficient set.
  assign coef_ok   = coef_we && !busy && !accept;

  always_comb begin
    rdy_en_d = 1'b1;
    valid_d  = valid_q;
    x_d      = x_q;
    acc_d    = acc_q;
    coef_d   = coef_q;

    if (advance) begin
      valid_d[0] = accept;
      if (accept) begin
        x_d[0]   = x;
        acc_d[0] = coef_q[DEGREE];
      end
      for (int k = 1; k <= DEGREE; k++) begin
        valid_d[k] = valid_q[k-1];
        x_d[k]     = x_q[k-1];
        acc_d[k]   = horner_step(acc_q[k-1], x_q[k-1], coef_q[DEGREE-k]);
      end
    end

    // Indices above DEGREE match no entry, so the write is ignored.
    for (int k = 0; k <= DEGREE; k++) begin
      if (coef_ok && (coef_addr == ADDR_W'(k))) begin
        coef_d[k] = coef_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
      valid_q  <= '0;
      for (int k = 0; k <= DEGREE; k++) begin
        x_q[k]    <= '0;
        acc_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      rdy_en_q <= rdy_en_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      coef_q   <= coef_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_horner_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_horner_pipe
// Purpose  : Self-checking bench for poly_horner_pipe.
//            The main instance uses WIDTH=16 and DEGREE=2. A second instance
//            uses DEGREE=1 and checks the boundary case at the extreme
//            input value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_horner_pipe;
  localparam int W  = 16;
  localparam int D  = 2;
  localparam int AW = $clog2(D + 1);

`ifdef POLY_HORNER_SAT_EN
  localparam int EXP_X200 = 32767;
  localparam int EXP_D1   = 32767;
`else
  localparam int EXP_X200 = -10668;
  localparam int EXP_D1   = -32761;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic                coef_we = 1'b0;
  logic [AW-1:0]       coef_addr = '0;
  logic signed [W-1:0] coef_wdata = '0;
  logic                busy;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] x = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] y;

  logic                d1_we = 1'b0;
  logic                d1_addr = 1'b0;
  logic signed [W-1:0] d1_wdata = '0;
  logic                d1_busy;
  logic                d1_in_valid = 1'b0;
  logic                d1_in_ready;
  logic signed [W-1:0] d1_x = '0;
  logic                d1_out_valid;
  logic signed [W-1:0] d1_y;

  always #5 clk = ~clk;

  poly_horner_pipe #(.WIDTH(W), .DEGREE(D)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  poly_horner_pipe #(.WIDTH(W), .DEGREE(1)) u_dut_d1 (
    .clk(clk), .rst_n(rst_n),
    .coef_we(d1_we), .coef_addr(d1_addr), .coef_wdata(d1_wdata),
    .busy(d1_busy),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .x(d1_x),
    .out_valid(d1_out_valid), .out_ready(1'b1), .y(d1_y)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic signed [W-1:0] shadow [0:D];
  int  exp_q[$];
  int  got_y[$];
  int  got_t[$];
  int  cyc = 0;
  int  rel_cnt = 0;
  bit  m_busy;
  bit  m_acc;

`ifdef POLY_HORNER_SAT_EN
  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int model_y(input int xv);
    longint acc, p;
    acc = shadow[D];
    for (int k = D - 1; k >= 0; k--) begin
      p   = clamp(acc * xv);
      acc = clamp(p + longint'(shadow[k]));
    end
    return int'(acc);
  endfunction
`else
  // The exact polynomial value, reduced modulo 2^W once at the end.
  function automatic int model_y(input int xv);
    longint s, pw;
    logic signed [W-1:0] r;
    s  = 0;
    pw = 1;
    for (int k = 0; k <= D; k++) begin
      s  = s + longint'(shadow[k]) * pw;
      pw = pw * xv;
    end
    r = s[W-1:0];
    return int'(r);
  endfunction
`endif

  // Compare process: samples on the falling edge, when all signals are stable.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_y", y, 0);
      exp_q.delete();
      for (int k = 0; k <= D; k++) shadow[k] = '0;
      rel_cnt = 0;
    end else begin
      if (rel_cnt < 2) rel_cnt++;
      if (rel_cnt == 1) check("in_ready_before_first_clk", in_ready, 0);
      else              check("in_ready_rule", in_ready, (!out_valid || out_ready));
      m_busy = (exp_q.size() != 0);
      m_acc  = in_valid && in_ready;
      check("busy_model", busy, m_busy);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_unexpected: y=%0d with no sample pending", y);
        end else begin
          check("y_model", y, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            got_y.push_back(int'(y));
            got_t.push_back(cyc);
          end
        end
      end
      if (m_acc) exp_q.push_back(model_y(int'(x)));
      if (coef_we && !m_busy && !m_acc && coef_addr <= AW'(D))
        shadow[coef_addr] = coef_wdata;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = W'(v);
    step();
    coef_we = 1'b0;
  endtask

  task automatic send_one(input int xv, input int exp_y, input string nm);
    int n; int lat; bit ok;
    in_valid = 1'b1; x = W'(xv); n = 0; ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk); ok = in_ready; step(); n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s_accept: in_ready=0 for %0d cycles, expected 1", nm, n);
      return;
    end
    lat = 0; ok = 1'b0;
    while (!ok && lat < 20) begin
      @(negedge clk); lat++; ok = out_valid;
    end
    check({nm, "_latency"}, lat, D + 1);
    check(nm, y, exp_y);
    step();
  endtask

  task automatic run_stream(input bit stall, input string nm);
    int idx; int n; int stalled;
    int exp_v[4];
    exp_v[0] = 4; exp_v[1] = 9; exp_v[2] = 20; exp_v[3] = 37;
    idx = 0; n = 0; stalled = 0;
    got_y.delete(); got_t.delete();
    while (got_y.size() < 4 && n < 60) begin
      out_ready = !(stall && stalled < 5);
      in_valid  = (idx < 4);
      x         = W'(idx);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && !out_ready) begin
        stalled++;
        check({nm, "_held_y"}, y, 4);
        check({nm, "_held_in_ready"}, in_ready, 0);
      end
      step(); n++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check({nm, "_count"}, got_y.size(), 4);
    if (got_y.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check({nm, "_y"}, got_y[i], exp_v[i]);
        if (!stall) check({nm, "_back_to_back"}, got_t[i] - got_t[0], i);
      end
    end
    if (stall) check({nm, "_stall_cycles"}, stalled, 5);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n; bit ok;
    // Reset held for a few cycles; the compare process checks the outputs.
    repeat (3) step();
    check("reset_y_literal", y, 0);
    rst_n = 1'b1;
    #1 check("in_ready_at_release", in_ready, 0);
    step();
    check("in_ready_after_first_clk", in_ready, 1);

    // Load C2=3, C1=2, C0=4 while idle. Address 3 lies above DEGREE and must be ignored.
    write_coef(2, 3);
    write_coef(1, 2);
    write_coef(0, 4);
    write_coef(3, 55);

    send_one(5,   89,       "x5");
    send_one(-3,  25,       "xm3");
    send_one(200, EXP_X200, "x200");

    run_stream(1'b0, "stream");
    run_stream(1'b1, "stall");

    // A write to C0 while a sample is in flight must be dropped.
    in_valid = 1'b1; x = '0;
    step();
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = AW'(0); coef_wdata = 16'sd100;
    @(negedge clk);
    check("busy_during_write", busy, 1);
    step();
    coef_we = 1'b0;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin @(negedge clk); ok = out_valid; n++; end
    check("c0_write_dropped_y", y, 4);
    step();
    write_coef(0, 100);
    send_one(0, 100, "c0_write_idle");
    write_coef(0, 4);

    // Reset with two samples in flight, the older one already at the output.
    in_valid = 1'b1; x = 16'sd5;
    step();
    x = -16'sd3;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_busy", busy, 0);
    out_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
    send_one(5, 0, "after_reset_no_reload");

    // DEGREE=1 instance: C1=-1, C0=7, x=-32768.
    d1_we = 1'b1; d1_addr = 1'b1; d1_wdata = -16'sd1;
    step();
    d1_addr = 1'b0; d1_wdata = 16'sd7;
    step();
    d1_we = 1'b0;
    d1_in_valid = 1'b1; d1_x = 16'sh8000;
    @(negedge clk);
    check("d1_in_ready", d1_in_ready, 1);
    step();
    d1_in_valid = 1'b0;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk); n++; ok = d1_out_valid;
      if (n == 1) check("d1_busy", d1_busy, 1);
    end
    check("d1_latency", n, 2);
    check("d1_y", d1_y, EXP_D1);
    step();

    repeat (2) step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
